// File: rtl/mc_inc_n_r.sv
// Half-pipelined incrementer: the low half plus its carry is registered, and the
// high half adds that carry to the live input, so inc_out is valid one edge after inc_in.
module mc_inc_n_r #(
  parameter int incN_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [incN_width-1:0] inc_in,
  output logic [incN_width-1:0] inc_out
);

  localparam int incN_center = incN_width / 2;
  localparam int HI_W        = incN_width - incN_center;

  // Bit incN_center carries out of the low half into the combinational high adder.
  logic [incN_center:0] low_reg;
  logic [incN_center:0] low_next;
  logic [HI_W-1:0]      high_sum;

  always_comb begin
    low_next = {1'b0, inc_in[incN_center-1:0]} + {{incN_center{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_reg <= '0;
    end else begin
      low_reg <= low_next;
    end
  end

  // Carry out of the top bit is dropped so the result wraps modulo 2^N.
  always_comb begin
    high_sum = inc_in[incN_width-1:incN_center] + HI_W'(low_reg[incN_center]);
  end

  assign inc_out = {high_sum, low_reg[incN_center-1:0]};

endmodule

// File: tb/tb_mc_inc_n_r.sv
// Scoreboard bench for mc_inc_n_r at width 24: expected values are queued when
// inc_in is driven and popped when the output is sampled.
module tb_mc_inc_n_r;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] inc_in;
  logic [N-1:0] inc_out;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  mc_inc_n_r #(.incN_width(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .inc_in (inc_in),
    .inc_out(inc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [N-1:0] exp;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got=%h", tag, inc_out);
    end else begin
      exp = exp_q.pop_front();
      check(tag, inc_out, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Drive a value, queue its increment, hold it across one edge, then compare.
  task automatic apply_hold(input string tag, input logic [N-1:0] v);
    inc_in = v;
    exp_q.push_back(v + 24'd1);
    edge_wait();
    pop_check(tag);
  endtask

  initial begin
    logic [N-1:0] model;
    logic [N-1:0] seq_exp[3];
    logic [N-1:0] r;

    rst    = 1'b1;
    inc_in = 24'h123456;
    edge_wait();
    exp_q.push_back(24'h123000);
    pop_check("reset_state");

    rst = 1'b0;
    exp_q.push_back(24'h123457);
    edge_wait();
    pop_check("reset_release");

    apply_hold("low_carry", 24'h000FFF);
    apply_hold("mid_carry", 24'h7FFFFF);
    apply_hold("full_wrap", 24'hFFFFFF);
    apply_hold("zero_in",   24'h000000);

    apply_hold("comb_base", 24'h000010);
    inc_in = 24'h500010;
    exp_q.push_back(24'h500011);
    #1;
    pop_check("comb_high");
    inc_in = 24'h500020;
    exp_q.push_back(24'h500011);
    #1;
    pop_check("stale_low");
    exp_q.push_back(24'h500021);
    edge_wait();
    pop_check("stale_settle");

    // Reset while carrying out of the low half clears the carry too.
    inc_in = 24'hABCFFF;
    rst    = 1'b1;
    exp_q.push_back(24'hABC000);
    edge_wait();
    pop_check("mid_reset");
    rst = 1'b0;
    exp_q.push_back(24'hABD000);
    edge_wait();
    pop_check("mid_reset_resume");

    // Feedback counter, one dependent increment every 2 clocks.
    seq_exp[0] = 24'h000FFF;
    seq_exp[1] = 24'h001000;
    seq_exp[2] = 24'h001001;
    model  = 24'h000FFE;
    inc_in = model;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq_exp[i]);
      edge_wait();
      edge_wait();
      check("feedback_model", seq_exp[i], model + 24'd1);
      pop_check("feedback");
      model  = model + 24'd1;
      inc_in = inc_out;
    end

    for (int i = 0; i < 1000; i++) begin
      r = N'($urandom());
      apply_hold("random", r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_inc_n_r.md
# mc_inc_n_r

Parameterized, half-pipelined incrementer for the memory controller's async-device address counter. It computes inc_in + 1 with the lower half registered and the upper half formed combinationally from the live input plus the registered carry. The result is valid one clock after inc_in settles. It sits beside the ACS address latch, instantiated with width 24, and feeds the next-address value back into that latch.

## Interface
Parameters:
- incN_width, default 32: operand/result width N (N ≥ 2).
- incN_center, derived, fixed at floor(N/2): split point C. Low half is bits [C-1:0]; high half is bits [N-1:C].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- inc_in  input  N  value to be incremented.
- inc_out  output  N  inc_in + 1, modulo 2^N (see Timing for validity).

## Operation
- Internal register low_r, width C+1.
- On each rising clk edge:
  - If rst = 1: low_r ← 0.
  - Otherwise: low_r ← zero-extended inc_in[C-1:0] + 1, where bit C holds the carry out of the low half.
  - rst has priority over the update.
- inc_out[C-1:0] = low_r[C-1:0], a registered value.
- inc_out[N-1:C] = inc_in[N-1:C] + low_r[C], computed combinationally from the current input.
  - Width N-C; the carry out of the top bit is discarded, so the result wraps modulo 2^N.
- No other state. No enable: low_r updates every non-reset cycle.
- After reset, low_r = 0, so inc_out = {inc_in[N-1:C], C'b0} until the first non-reset edge.

## Timing
- Latency: one clock. inc_out equals inc_in + 1 from the edge after inc_in was sampled, provided inc_in is unchanged since that edge.
- The high half reacts combinationally to inc_in[N-1:C].
- The low half and carry reflect inc_in as sampled at the previous edge.
- If inc_in changes between edges, inc_out is a mix of old and new values and must not be used until one edge later.
- Users must space dependent increments by at least 2 clocks. This applies to the feedback loop acs_addr ← inc_out.
- Boundary conditions:
  - Low half all ones: carry = 1, low result = 0, high half = inc_in_hi + 1.
  - inc_in all ones: inc_out = 0 (wrap).
  - inc_in = 0: inc_out = 1.
- Reset mid-operation: the edge with rst = 1 clears low_r; the following non-reset edge resumes normal operation with no extra delay.
- No X propagation from rst is permitted: rst = 0 or 1 only.

## Test plan
All cases use N = 24, C = 12.
- Reset: hold inc_in = 0x123456 with rst = 1 for 1 edge -> inc_out = 0x123000. Release rst, 1 edge -> inc_out = 0x123457.
- Low-half carry: inc_in = 0x000FFF, 1 edge -> inc_out = 0x001000. Also inc_in = 0x7FFFFF, 1 edge -> 0x800000.
- Full wrap: inc_in = 0xFFFFFF, 1 edge -> inc_out = 0x000000. Also inc_in = 0x000000, 1 edge -> 0x000001.
- Combinational high half: inc_in = 0x000010, 1 edge (inc_out = 0x000011). Then change inc_in to 0x500010 with no edge -> inc_out = 0x500011 immediately.
- Stale low half: after the previous case, set inc_in = 0x500020 with no edge -> inc_out = 0x500011. After 1 edge -> 0x500021.
- Feedback counter: start from 0x000FFE and load inc_out back into inc_in every 2 clocks -> sequence 0x000FFF, 0x001000, 0x001001. Also random inc_in held 1 edge -> inc_out == (inc_in + 1) mod 2^24 for 1000 vectors.
